// File: rtl/if_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_stage_pkg
// Description : Shared constants and fetch-state encoding for the IF stage.
// Revision    : 1.0 - initial release
// ============================================================================
package if_stage_pkg;

    // First fetch address after reset.
    localparam logic [31:0] c_RESET_PC  = 32'h1c00_0000;

    // Canonical NOP encoding (andi r0, r0, 0).
    localparam logic [31:0] c_NOP_INST  = 32'h0340_0000;

    // Fetch FSM encoding.
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,   // ready to issue a request
        S_WAIT = 2'd1,   // one request outstanding
        S_HOLD = 2'd2    // buffer full, waiting for ID
    } fs_state_e;

    // Fetch addresses are always word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fs_inst_buf.sv
`default_nettype none
// ============================================================================
// Module      : fs_inst_buf
// Description : One-entry {valid, pc, inst} buffer between fetch and decode.
//               Flush beats load, load beats drain.
// Revision    : 1.0 - initial release
// ============================================================================
module fs_inst_buf
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] load_pc,
    input  logic [31:0] load_inst,
    input  logic        drain,
    input  logic        flush,
    output logic        valid,
    output logic [31:0] pc,
    output logic [31:0] inst
);

    logic        r_valid;
    logic [31:0] r_pc;
    logic [31:0] r_inst;

    // Buffer contents: a redirect flush wins over everything else.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_pc    <= RESET_PC;
            r_inst  <= 32'h0;
        end else begin
            if (flush) begin
                r_valid <= 1'b0;
            end else if (load) begin
                r_valid <= 1'b1;
                r_pc    <= load_pc;
                r_inst  <= load_inst;
            end else if (drain) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign valid = r_valid;
    assign pc    = r_pc;
    assign inst  = r_inst;

endmodule
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_stage
// Description : Instruction-fetch stage. Owns the fetch PC, drives a
//               req/addr_ok/data_ok SRAM bus with one outstanding request,
//               buffers one instruction for ID and handles branch redirects
//               including discard of wrong-path responses.
// Revision    : 1.0 - initial release
// ============================================================================
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ds_allow_in,
    input  logic        br_taken_cancel,
    input  logic [31:0] br_target,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        to_ds_valid,
    output logic [31:0] fs_pc,
    output logic [31:0] fs_inst
);

    fs_state_e   r_state;
    fs_state_e   w_state_nxt;
    logic [31:0] r_fetch_pc;
    logic [31:0] w_fetch_pc_nxt;
    logic [31:0] r_req_pc;        // address of the outstanding request
    logic [31:0] w_req_pc_nxt;
    logic [31:0] r_br_tgt;        // redirect target waiting for a wrong-path response
    logic [31:0] w_br_tgt_nxt;
    logic        r_discard;       // outstanding response is wrong-path
    logic        w_discard_nxt;
    logic        r_pend_br;       // latched target must be fetched once the response drains
    logic        w_pend_br_nxt;

    logic        w_buf_valid;
    logic        w_buf_load;
    logic        w_buf_drain;
    logic        w_buf_flush;
    logic        w_transfer;
    logic        w_req_state;
    logic        w_req_fire;
    logic        w_rsp;
    logic [31:0] w_tgt;

    assign w_tgt       = word_align(br_target);
    assign w_transfer  = w_buf_valid & ds_allow_in;

    // A request may go out whenever the buffer is empty or drains this cycle.
    assign w_req_state = (r_state == S_REQ) | ((r_state == S_HOLD) & w_transfer);
    assign inst_req    = ~reset & w_req_state;
    assign inst_addr   = r_fetch_pc;
    assign w_req_fire  = inst_req & inst_addr_ok;

    // Responses only count while a request is outstanding.
    assign w_rsp       = (r_state == S_WAIT) & inst_data_ok;

    // State and fetch bookkeeping registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_REQ;
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= RESET_PC;
            r_br_tgt   <= RESET_PC;
            r_discard  <= 1'b0;
            r_pend_br  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_req_pc   <= w_req_pc_nxt;
            r_br_tgt   <= w_br_tgt_nxt;
            r_discard  <= w_discard_nxt;
            r_pend_br  <= w_pend_br_nxt;
        end
    end

    // Next-state logic; a redirect overrides every other event this cycle.
    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_req_pc_nxt   = r_req_pc;
        w_br_tgt_nxt   = r_br_tgt;
        w_discard_nxt  = r_discard;
        w_pend_br_nxt  = r_pend_br;
        w_buf_load     = 1'b0;
        w_buf_drain    = 1'b0;
        w_buf_flush    = 1'b0;

        if (br_taken_cancel) begin
            w_buf_flush = 1'b1;
            if (r_state == S_WAIT) begin
                if (w_rsp) begin
                    // Wrong-path data arrives with the redirect: drop it and go.
                    w_state_nxt    = S_REQ;
                    w_fetch_pc_nxt = w_tgt;
                    w_discard_nxt  = 1'b0;
                    w_pend_br_nxt  = 1'b0;
                end else begin
                    // Still waiting: remember the target (newest cancel wins).
                    w_discard_nxt  = 1'b1;
                    w_pend_br_nxt  = 1'b1;
                    w_br_tgt_nxt   = w_tgt;
                end
            end else if (w_req_fire) begin
                // The request accepted this cycle is already wrong-path.
                w_state_nxt    = S_WAIT;
                w_req_pc_nxt   = r_fetch_pc;
                w_discard_nxt  = 1'b1;
                w_pend_br_nxt  = 1'b1;
                w_br_tgt_nxt   = w_tgt;
            end else begin
                w_state_nxt    = S_REQ;
                w_fetch_pc_nxt = w_tgt;
            end
        end else begin
            case (r_state)
                S_REQ: begin
                    if (w_req_fire) begin
                        w_state_nxt    = S_WAIT;
                        w_req_pc_nxt   = r_fetch_pc;
                        w_fetch_pc_nxt = r_fetch_pc + 32'd4;
                    end
                end
                S_WAIT: begin
                    if (w_rsp) begin
                        if (r_discard) begin
                            w_state_nxt   = S_REQ;
                            w_discard_nxt = 1'b0;
                            if (r_pend_br) begin
                                w_fetch_pc_nxt = r_br_tgt;
                                w_pend_br_nxt  = 1'b0;
                            end
                        end else begin
                            w_state_nxt = S_HOLD;
                            w_buf_load  = 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (w_transfer) begin
                        w_buf_drain = 1'b1;
                        if (w_req_fire) begin
                            w_state_nxt    = S_WAIT;
                            w_req_pc_nxt   = r_fetch_pc;
                            w_fetch_pc_nxt = r_fetch_pc + 32'd4;
                        end else begin
                            w_state_nxt    = S_REQ;
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_REQ;
                end
            endcase
        end
    end

    fs_inst_buf #(
        .RESET_PC (RESET_PC)
    ) u_fs_inst_buf (
        .clk       (clk),
        .reset     (reset),
        .load      (w_buf_load),
        .load_pc   (r_req_pc),
        .load_inst (inst_rdata),
        .drain     (w_buf_drain),
        .flush     (w_buf_flush),
        .valid     (w_buf_valid),
        .pc        (fs_pc),
        .inst      (fs_inst)
    );

    assign to_ds_valid = w_buf_valid;

endmodule
`default_nettype wire
